axis_pkt_gen: RTL and testbench
===============================

Name: axis_pkt_gen

Overview:
- Synthesizable AXI-Stream packet transmitter (traffic generator) for the queueing datapath.
- Emits configurable bursts of packets with a deterministic, checkable payload on a 512-bit master interface.
- It is the hardware source counterpart of the packet sink. It drives the queue/FIFO ingress on-chip, where file-based stimulus is unavailable.

Parameters:
- AXIS_DATA_WIDTH, 512, tdata width in bits (multiple of 32).
- KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width; bytes per beat.
- MIN_PKT_LEN, 60, lower clamp for packet length in bytes.
- MAX_PKT_LEN, 9600, upper clamp for packet length in bytes.

Ports:
- clk_i  in  1  single clock.
- resetn_i  in  1  asynchronous active-low reset.
- start_i  in  1  start a burst; sampled only in IDLE.
- stop_i  in  1  graceful stop request; level or pulse.
- pkt_len_i  in  16  packet length in bytes; latched at start.
- pkt_count_i  in  32  packets per burst; 0 = run until stopped.
- gap_i  in  16  idle cycles between packets; latched at start.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse at burst end.
- m_axis_tvalid_o  out  1  AXIS valid.
- m_axis_tready_i  in  1  AXIS ready.
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  AXIS data.
- m_axis_tkeep_o  out  KEEP_WIDTH  AXIS byte enables.
- m_axis_tlast_o  out  1  last beat of packet.
- m_axis_tuser_o  out  1  always 0.

Behaviour:
- Reset (async, resetn_i=0):
  - All outputs 0.
  - FSM returns to IDLE; counters cleared.
  - Takes effect immediately, even mid-packet; the partial packet is abandoned.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE: start_i=1 latches len, count and gap, clears seq to 0, sets busy_o=1, then → SEND. The first beat is valid on the next cycle.
  - SEND: presents beats.
    - On handshake (tvalid & tready) of a non-last beat: advance beat index.
    - On handshake of the last beat: seq+1, then evaluate the end condition (below).
  - GAP: tvalid=0 for exactly gap cycles → SEND.
  - DONE: done_o=1 for one cycle, busy_o=0 → IDLE.
- Last-beat end condition:
  - Burst ends when (count≠0 and seq+1==count) or stop is pending → DONE.
  - Otherwise, gap==0 → stay in SEND; tvalid remains high and the next packet's first beat is presented the following cycle.
  - Otherwise → GAP.
- Length and beat arithmetic:
  - Effective len = clamp(pkt_len_i, MIN_PKT_LEN, MAX_PKT_LEN).
  - Beats = ceil(len/KEEP_WIDTH).
  - Remainder r = len mod KEEP_WIDTH.
  - Last-beat tkeep = r==0 ? all ones : (1<<r)-1; all other beats are all ones.
  - tkeep is always contiguous from byte 0.
- Payload:
  - Byte i of beat b = (b*KEEP_WIDTH+i)[7:0].
  - Exception: beat 0 bytes 0..3 = seq[31:0], little-endian.
  - Bytes with tkeep=0 are driven 0.
- Handshake:
  - Once tvalid is high, tdata, tkeep and tlast are held stable until tready.
  - tvalid never drops without a handshake, except on reset.
  - tvalid does not depend combinationally on tready.
- stop_i:
  - Captured in a sticky flag while busy; cleared on DONE.
  - Never truncates a packet; the current packet completes.
  - If asserted in GAP: → DONE at the end of the gap, with no further packet sent.
- start_i while busy: ignored.
- Latency: start_i at cycle 0 → tvalid at cycle 1.
- seq wraps modulo 2^32.

Optional Feature:
- Macro AXIS_PKT_GEN_STATS_EN.
- Defined: adds output ports
  - stat_pkt_cnt_o (32): packets completed (last-beat handshakes).
  - stat_byte_cnt_o (48): sum of effective len.
  - stat_stall_cnt_o (32): cycles with tvalid & !tready.
  - All three clear on reset and on an accepted start, and saturate at max.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package axis_pkt_gen_pkg:
  - State enum (IDLE, SEND, GAP, DONE).
  - MIN/MAX length defaults.
  - Function len_to_keep(r).
- One natural sub-module: axis_pkt_gen_payload. Combinational beat index + seq + len → tdata/tkeep/tlast. It is reusable by the matching checker.

Test Plan:
- len=64, count=1, gap=0, tready=1 → one beat; tkeep=all ones; tlast=1; bytes 0..3=0, bytes 4..63=4..63; done_o pulse 1 cycle after the handshake.
- len=65, count=2, gap=0 → 2 beats per packet; last tkeep=0x1; 4 back-to-back beats with tvalid continuously high; seq 0 then 1.
- len=130, count=3, gap=2 → 3 beats per packet; last tkeep=0x3; exactly 2 tvalid-low cycles between packets; 9 handshakes total.
- len=20 and len=20000 → clamped to 60 (tkeep 60 ones) and 9600 (150 beats, last tkeep all ones).
- Random tready (50%), count=4 → tdata/tkeep/tlast stable while stalled; no lost or duplicated beats; stat_stall_cnt_o equals observed stall cycles (macro defined).
- count=0, stop_i pulsed mid-packet 5 → packet 5 completes fully, then done_o, no packet 6. Separately: resetn_i low mid-packet → all outputs 0 immediately; new start produces seq 0.

Source files
------------

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator and its matching checker.
// State encoding, default length clamps and the last-beat byte-enable helper.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  localparam int unsigned DEF_MIN_PKT_LEN = 60;
  localparam int unsigned DEF_MAX_PKT_LEN = 9600;
  localparam int unsigned MAX_KEEP_WIDTH  = 128;

  // Contiguous byte enable for a beat holding r valid bytes; r==0 means a full beat.
  function automatic logic [MAX_KEEP_WIDTH-1:0] len_to_keep(input int unsigned r);
    logic [MAX_KEEP_WIDTH-1:0] one;
    one = MAX_KEEP_WIDTH'(1);
    if (r == 0) return '1;
    return (one << r) - one;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_payload.sv
// Combinational payload former: beat index, sequence number and effective length
// map to tdata/tkeep/tlast. Reusable by the matching packet checker.
module axis_pkt_gen_payload
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH      = AXIS_DATA_WIDTH / 8
) (
  input  logic [15:0]                beat,
  input  logic [31:0]                seq,
  input  logic [15:0]                len,
  output logic [AXIS_DATA_WIDTH-1:0] tdata,
  output logic [KEEP_WIDTH-1:0]      tkeep,
  output logic                       tlast
);

  logic [31:0]               beats;
  logic [31:0]               rem;
  logic [31:0]               base;
  logic [MAX_KEEP_WIDTH-1:0] last_keep;

  always_comb begin
    beats     = (32'(len) + KEEP_WIDTH - 1) / KEEP_WIDTH;
    rem       = 32'(len) % KEEP_WIDTH;
    tlast     = (32'(beat) == beats - 32'd1);
    last_keep = len_to_keep(rem);
    tkeep     = tlast ? last_keep[KEEP_WIDTH-1:0] : '1;
    base      = 32'(beat) * KEEP_WIDTH;
    tdata     = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (tkeep[i]) tdata[i*8 +: 8] = 8'(base + i);
    end
    // First four bytes of a packet carry the sequence number, little-endian.
    if (beat == 16'd0) begin
      for (int unsigned j = 0; j < 4; j++) begin
        if (tkeep[j]) tdata[j*8 +: 8] = seq[j*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: bursts of clamped-length packets with a checkable payload.
// Define AXIS_PKT_GEN_STATS_EN to add the saturating packet/byte/stall counter outputs.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int unsigned MIN_PKT_LEN     = DEF_MIN_PKT_LEN,
  parameter int unsigned MAX_PKT_LEN     = DEF_MAX_PKT_LEN
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [15:0]                pkt_len_i,
  input  logic [31:0]                pkt_count_i,
  input  logic [15:0]                gap_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep_o,
  output logic                       m_axis_tlast_o,
  output logic                       m_axis_tuser_o
`ifdef AXIS_PKT_GEN_STATS_EN
  ,
  output logic [31:0]                stat_pkt_cnt_o,
  output logic [47:0]                stat_byte_cnt_o,
  output logic [31:0]                stat_stall_cnt_o
`endif
);

  state_t      state;
  logic [15:0] len;
  logic [15:0] gap;
  logic [15:0] gap_cnt;
  logic [15:0] beat;
  logic [31:0] count;
  logic [31:0] seq;
  logic        stop_pend;
  logic        busy;
  logic        done;
  logic        tvalid;

  logic [15:0]                eff_len;
  logic [AXIS_DATA_WIDTH-1:0] pay_data;
  logic [KEEP_WIDTH-1:0]      pay_keep;
  logic                       pay_last;
  logic                       handshake;
  logic                       burst_end;

  always_comb begin
    if (pkt_len_i < 16'(MIN_PKT_LEN))      eff_len = 16'(MIN_PKT_LEN);
    else if (pkt_len_i > 16'(MAX_PKT_LEN)) eff_len = 16'(MAX_PKT_LEN);
    else                                   eff_len = pkt_len_i;
  end

  axis_pkt_gen_payload #(
    .AXIS_DATA_WIDTH(AXIS_DATA_WIDTH),
    .KEEP_WIDTH     (KEEP_WIDTH)
  ) u_payload (
    .beat (beat),
    .seq  (seq),
    .len  (len),
    .tdata(pay_data),
    .tkeep(pay_keep),
    .tlast(pay_last)
  );

  assign handshake = tvalid & m_axis_tready_i;
  // A stop arriving on the same cycle as the last beat still ends the burst there.
  assign burst_end = ((count != '0) && (seq + 32'd1 == count)) || stop_pend || stop_i;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= IDLE;
      len       <= '0;
      gap       <= '0;
      gap_cnt   <= '0;
      beat      <= '0;
      count     <= '0;
      seq       <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tvalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_i) begin
            len       <= eff_len;
            count     <= pkt_count_i;
            gap       <= gap_i;
            seq       <= '0;
            beat      <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b1;
            tvalid    <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (stop_i) stop_pend <= 1'b1;
          if (handshake) begin
            if (!pay_last) begin
              beat <= beat + 16'd1;
            end else begin
              seq  <= seq + 32'd1;
              beat <= '0;
              if (burst_end) begin
                tvalid <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= DONE;
              end else if (gap != '0) begin
                tvalid  <= 1'b0;
                gap_cnt <= gap;
                state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (stop_i) stop_pend <= 1'b1;
          if (gap_cnt <= 16'd1) begin
            if (stop_pend || stop_i) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              tvalid <= 1'b1;
              state  <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          stop_pend <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload is gated by tvalid so every data output reads zero whenever nothing is offered.
  assign busy_o          = busy;
  assign done_o          = done;
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = tvalid ? pay_data : '0;
  assign m_axis_tkeep_o  = tvalid ? pay_keep : '0;
  assign m_axis_tlast_o  = tvalid & pay_last;
  assign m_axis_tuser_o  = 1'b0;

`ifdef AXIS_PKT_GEN_STATS_EN
  logic [31:0] pkt_cnt;
  logic [47:0] byte_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pkt_cnt   <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == IDLE && start_i) begin
      pkt_cnt   <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake && pay_last) begin
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
        if (byte_cnt > ('1 - 48'(len))) byte_cnt <= '1;
        else                            byte_cnt <= byte_cnt + 48'(len);
      end
      if (tvalid && !m_axis_tready_i && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_pkt_cnt_o   = pkt_cnt;
  assign stat_byte_cnt_o  = byte_cnt;
  assign stat_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: a byte-stream packet model fills an expected-beat
// queue; a negedge monitor pops and compares on every handshake.
module tb_axis_pkt_gen;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned LIMIT = 20000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start, stop;
  logic [15:0]   pkt_len, gap_in;
  logic [31:0]   pkt_count;
  logic          busy, done, tvalid, tready, tlast, tuser;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
`ifdef AXIS_PKT_GEN_STATS_EN
  logic [31:0]   stat_pkt, stat_stall;
  logic [47:0]   stat_byte;
`endif

  always #5 clk = ~clk;

  axis_pkt_gen #(.AXIS_DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .start_i        (start),
    .stop_i         (stop),
    .pkt_len_i      (pkt_len),
    .pkt_count_i    (pkt_count),
    .gap_i          (gap_in),
    .busy_o         (busy),
    .done_o         (done),
    .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready),
    .m_axis_tdata_o (tdata),
    .m_axis_tkeep_o (tkeep),
    .m_axis_tlast_o (tlast),
    .m_axis_tuser_o (tuser)
`ifdef AXIS_PKT_GEN_STATS_EN
    ,
    .stat_pkt_cnt_o  (stat_pkt),
    .stat_byte_cnt_o (stat_byte),
    .stat_stall_cnt_o(stat_stall)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned gaps[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned hs_count = 0;
  int unsigned stalls = 0;
  int unsigned low_run = 0;
  int unsigned cyc = 0;
  int unsigned last_hs_cyc = 0;
  bit          after_last = 0;
  bit          rdy_rand = 0;
  bit          stable_pend = 0;
  beat_t       held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned eff_len(input int unsigned len);
    if (len < 60) return 60;
    if (len > 9600) return 9600;
    return len;
  endfunction

  // Model: a packet is a byte stream where byte k is k mod 256, except the first
  // four bytes hold seq little-endian; the stream is cut into KW-byte beats.
  function automatic void push_packet(input logic [31:0] seq, input int unsigned len);
    int unsigned eff = eff_len(len);
    int unsigned nb = (eff + KW - 1) / KW;
    logic [31:0] k;
    for (int unsigned b = 0; b < nb; b++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int unsigned i = 0; i < KW; i++) begin
        k = b * KW + i;
        if (k < eff) begin
          e.keep[i] = 1'b1;
          e.data[i*8 +: 8] = (k < 4) ? seq[k*8 +: 8] : k[7:0];
        end
      end
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      stable_pend = 0;
    end else begin
      if (stable_pend) begin
        chk("stall_tvalid_held", 64'(tvalid), 64'd1);
        chk_wide("stall_tdata_held", tdata, held.data);
        chk("stall_ctrl_held", 64'({tkeep, tlast}), 64'({held.keep, held.last}));
      end
      stable_pend = 0;
      if (tvalid && !tready) begin
        stalls++;
        stable_pend = 1;
        held.data = tdata;
        held.keep = tkeep;
        held.last = tlast;
      end
      if (tvalid) begin
        if (after_last) begin
          gaps.push_back(low_run);
          after_last = 0;
        end
        low_run = 0;
      end else if (after_last) begin
        low_run++;
      end
      if (tvalid && tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(hs_count), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk_wide("tdata", tdata, e.data);
          chk("tkeep", 64'(tkeep), 64'(e.keep));
          chk("tlast_tuser", 64'({tlast, tuser}), 64'({e.last, 1'b0}));
        end
        if (tlast) begin
          after_last = 1;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic begin_burst(input int unsigned len, input logic [31:0] count,
                             input int unsigned gap, input bit rand_rdy);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    rdy_rand = rand_rdy;
    gaps.delete();
    after_last = 0;
    hs_count = 0;
    stalls = 0;
    pkt_len = 16'(len);
    pkt_count = count;
    gap_in = 16'(gap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_tvalid", 64'(tvalid), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input bit end_on_hs);
    int unsigned n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (done) begin
      if (end_on_hs) chk("done_after_last_hs", 64'(cyc), 64'(last_hs_cyc + 1));
      chk("busy_low_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end
    rdy_rand = 0;
  endtask

  task automatic run_burst(input int unsigned len, input int unsigned count,
                           input int unsigned gap, input bit rand_rdy);
    int unsigned nb = (eff_len(len) + KW - 1) / KW;
    for (int unsigned s = 0; s < count; s++) push_packet(32'(s), len);
    begin_burst(len, 32'(count), gap, rand_rdy);
    wait_done(1);
    chk("handshakes", 64'(hs_count), 64'(nb * count));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("gap_count", 64'(gaps.size()), 64'(count - 1));
    foreach (gaps[g]) chk("gap_len", 64'(gaps[g]), 64'(gap));
  endtask

  task automatic run_stop(input int unsigned len, input int unsigned gap, input int unsigned stop_hs,
                          input int unsigned delay, input int unsigned npkt, input bit end_on_hs);
    int unsigned nb = (eff_len(len) + KW - 1) / KW;
    int unsigned n = 0;
    for (int unsigned s = 0; s < npkt; s++) push_packet(32'(s), len);
    begin_burst(len, 32'd0, gap, 0);
    while (hs_count < stop_hs && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("stop_point_reached", 64'(hs_count >= stop_hs), 64'd1);
    repeat (delay) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(end_on_hs);
    repeat (4) @(negedge clk);
    chk("stop_handshakes", 64'(hs_count), 64'(nb * npkt));
    chk("stop_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pkt_len = '0;
    pkt_count = '0;
    gap_in = '0;
    #1;
    chk("reset_ctrl", 64'({busy, done, tvalid, tlast, tuser}), 64'd0);
    chk("reset_tkeep", 64'(tkeep), 64'd0);
    chk_wide("reset_tdata", tdata, '0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    run_burst(64, 1, 0, 0);
    run_burst(65, 2, 0, 0);
    run_burst(130, 3, 2, 0);
    run_burst(20, 1, 0, 0);
    run_burst(20000, 1, 1, 0);
    run_burst(200, 4, 1, 1);
`ifdef AXIS_PKT_GEN_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'(stalls));
    chk("stat_pkt", 64'(stat_pkt), 64'd4);
    chk("stat_byte", 64'(stat_byte), 64'd800);
`endif
    for (int unsigned r = 0; r < 4; r++) begin
      run_burst($urandom_range(1, 400), $urandom_range(1, 3), $urandom_range(0, 3), 1);
    end

    // Stop during the first beat of seq 5: packet completes, then no more.
    run_stop(130, 0, 16, 0, 6, 1);
    // Stop while in the gap after the first packet.
    run_stop(64, 4, 1, 2, 1, 0);

    // Asynchronous reset in the middle of a packet.
    push_packet(32'd0, 300);
    push_packet(32'd1, 300);
    begin_burst(300, 32'd2, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({busy, done, tvalid, tlast, tuser}), 64'd0);
    chk("midrst_tkeep", 64'(tkeep), 64'd0);
    chk_wide("midrst_tdata", tdata, '0);
`ifdef AXIS_PKT_GEN_STATS_EN
    chk("midrst_stats", 64'(stat_pkt) | 64'(stat_stall) | 64'(stat_byte), 64'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    run_burst(64, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
